// File: rtl/fetch_unit.sv
// rv32 instruction fetch stage: owns the PC, issues in-order imem requests,
// buffers returned words in a small prefetch FIFO and hands {pc, ir, error} to decode.
module fetch_unit #(
  parameter logic [31:0] TEXT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_error,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_ir,
  output logic        id_error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        err;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [31:0]   pcq_q [DEPTH];
  logic [31:0]   pcq_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [31:0]   pc_q, pc_d;
  logic          active_q;
  logic          id_valid_q, id_valid_d;
  entry_t        head_q, head_d;

  logic          pop, grant, resp, drop, push;
  logic [OW-1:0] occ;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_addr[1:0];

  // Issue decision, response classification and next-state for PC, counters, PC queue and FIFO.
  always_comb begin
    pop       = id_valid_q & id_ready & ~redirect;
    occ       = OW'(count_q) + OW'(outst_q) - OW'(pop);
    imem_req  = active_q & ~redirect & (occ < OW'(DEPTH));
    grant     = imem_req & imem_gnt;
    resp      = imem_rvalid & (outst_q != '0);
    drop      = resp & (discard_q != '0);
    push      = resp & ~drop & ~redirect;

    pc_d      = pc_q;
    outst_d   = outst_q + CW'(grant) - CW'(resp);
    discard_d = discard_q - CW'(drop);
    pcq_d     = pcq_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (grant) begin
      pc_d            = pc_q + 32'd4;
      pcq_d[pcq_wr_q] = pc_q;
      pcq_wr_d        = pcq_wr_q + AW'(1);
    end

    if (redirect) begin
      // Everything still in flight belongs to the abandoned path.
      pc_d      = {redirect_addr[31:2], 2'b00};
      discard_d = outst_d;
      pcq_wr_d  = '0;
      pcq_rd_d  = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: pcq_q[pcq_rd_q], ir: imem_rdata, err: imem_error};
        wr_ptr_d        = wr_ptr_q + AW'(1);
        pcq_rd_d        = pcq_rd_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    id_valid_d = (count_d != '0);
    head_d     = mem_d[rd_ptr_d];
  end

  // State registers; the decode-facing head is registered so imem_rdata never reaches id_ir combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= TEXT_ADDR;
      active_q   <= 1'b0;
      outst_q    <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      id_valid_q <= 1'b0;
      head_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        pcq_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      active_q   <= 1'b1;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      id_valid_q <= id_valid_d;
      head_q     <= head_d;
      mem_q      <= mem_d;
      pcq_q      <= pcq_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = head_q.pc;
  assign id_ir     = head_q.ir;
  assign id_error  = head_q.err;

  // FIFO never overflows, and every response matches an outstanding request.
  assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && (count_q == CW'(DEPTH))));
  assert property (@(posedge clk) disable iff (!resetn)
    imem_rvalid |-> (outst_q != '0));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of decode in the rv32 pipeline.
- Owns the PC, issues in-order requests to a pipelined instruction-memory port, buffers returned words in a small prefetch FIFO, and presents {pc, ir, error} to decode with a valid/ready handshake.
- Accepts redirects (taken branch, jump, trap) from execute: flushes buffered words, drops in-flight responses and restarts fetch at the new address.

Parameters:
- TEXT_ADDR, 32'h0000_0000, PC value after reset.
- DEPTH, 2, prefetch FIFO entries; also the cap on buffered plus in-flight fetches (power of two, ≥2).

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- redirect  input  1  restart fetch at redirect_addr (from execute pc_sel ≠ PC_NEXT)
- redirect_addr  input  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  output  1  request valid
- imem_addr  output  32  word-aligned request address
- imem_gnt  input  1  request accepted this cycle when imem_req=1
- imem_rvalid  input  1  response valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  input  32  instruction word
- imem_error  input  1  access fault, qualified by imem_rvalid
- id_valid  output  1  FIFO head valid
- id_ready  input  1  decode consumes head when id_valid=1
- id_pc  output  32  PC of head instruction
- id_ir  output  32  head instruction word
- id_error  output  1  head fetch faulted

Behaviour:
- Reset (async assert, sync release to clk): pc=TEXT_ADDR, FIFO empty, outstanding=0, discard=0, imem_req=0, id_valid=0, id_pc=0, id_ir=0 (NOP is not required), id_error=0.
- Issue rule: imem_req=1 when (count + outstanding − pop) < DEPTH and redirect=0; pop = id_valid & id_ready. imem_addr = pc.
- On imem_req & imem_gnt: pc += 4 (wraps mod 2^32), outstanding += 1. While imem_req=1 and gnt=0, imem_addr and imem_req hold stable (no retraction).
- On imem_rvalid: outstanding −= 1; if discard>0, discard −= 1 and word dropped; else {pc_of_request, rdata, error} pushed. Request PCs are tracked in a DEPTH-entry PC queue written at grant, read at response.
- FIFO outputs are registered: a response accepted in cycle N is visible on id_* in cycle N+1. No combinational path from imem_rdata to id_ir.
- Throughput: with gnt tied 1, 1-cycle response latency and id_ready=1, one instruction per cycle sustained; first id_valid 3 cycles after reset release (req cycle 0, rvalid cycle 1, visible cycle 2 counting from first req).
- Redirect (cycle R): FIFO and PC queue cleared; pop in R ignored; pc <= {redirect_addr[31:2],2'b00}; imem_req forced 0 in R; discard <= outstanding after R's grant/response updates (i.e. requests granted in R and responses not yet returned, excluding any response arriving in R, which is dropped). First new request issued in R+1.
- Redirect while discard>0: discard accumulates correctly; no stale word ever reaches decode.
- Simultaneous push and pop on full FIFO: allowed only because issue rule guarantees space; overflow is an assertion failure. Response with outstanding=0 is an assertion failure.
- imem_error: word stored with id_error=1; fetch continues; decode/trap logic acts on it.
- Reset mid-operation: all state returns to reset values immediately; responses arriving after release with outstanding=0 are ignored (memory must be reset together).

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid, id_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; id_pc 0x0,0x4,0x8 with matching id_ir, one per cycle.
- id_ready=0 for 10 cycles -> exactly DEPTH (2) requests issued, imem_req drops, id_pc holds 0x0; on id_ready=1 words 0x0,0x4 then 0x8 delivered, none lost or duplicated.
- imem_gnt=0 for 3 cycles with req pending -> imem_addr stable at 0x8, imem_req stays 1, pc advances only on grant.
- Redirect to 0x100 with 2 responses in flight (3-cycle latency) -> both stale responses dropped, next id_pc=0x100, then 0x104; redirect_addr 0x203 -> fetch at 0x200.
- Response with imem_error=1 at 0xC -> id_pc=0xC, id_error=1; next instruction 0x10 with id_error=0.
- resetn asserted mid-stream with FIFO full -> id_valid=0 and imem_req=0 same cycle; after release first imem_addr=TEXT_ADDR.
